// File: rtl/qarma64_req_ctrl_pkg.sv
// Shared constants and FSM state encoding for the Qarma64 request front-end.
package qarma64_req_ctrl_pkg;

  localparam int unsigned CORE_LAT    = 17;
  localparam int unsigned LOAD_CYCLES = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/qarma64_req_ctrl_if.sv
// Request and result handshake bundle; the controller is the slave side.
interface qarma64_req_ctrl_if #(
  parameter int unsigned TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [63:0]      req_data;
  logic [63:0]      req_tweak;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output req_valid, req_data, req_tweak, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_data, req_tweak, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
  );
endinterface

// File: rtl/qarma64_req_ctrl_fifo.sv
// Synchronous request FIFO; caller guarantees no push when full and no pop when empty.
module qarma_req_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 132
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/qarma64_req_ctrl.sv
// Qarma64 request front-end: queues requests, runs the core one at a time,
// returns results with a watchdog error for a hung core.
module qarma64_req_ctrl
  import qarma64_req_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [127:0]        key,
  qarma64_req_ctrl_if.slave   bus,
  output logic                busy,
  output logic                core_rst_n,
  output logic [63:0]         core_in,
  output logic [63:0]         core_tweak,
  output logic [127:0]        core_key,
  input  logic [63:0]         core_out,
  input  logic                core_ready
);
  localparam int unsigned FW = 128 + TAG_W;
  localparam int unsigned CW = $clog2(TIMEOUT);

  state_t           state, state_n;
  logic [CW-1:0]    run_cnt;
  logic             push, pop, full, empty, capture, timeout_hit;
  logic [FW-1:0]    fifo_rdata;
  logic [TAG_W-1:0] cur_tag;
  logic             rsp_valid_q, rsp_err_q;
  logic [63:0]      rsp_data_q;
  logic [TAG_W-1:0] rsp_tag_q;

  assign push          = bus.req_valid & ~full;
  assign bus.req_ready = ~full;
  assign timeout_hit   = (run_cnt == CW'(TIMEOUT - 1));
  assign busy          = (state != S_IDLE) | ~empty;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_err   = rsp_err_q;

  qarma_req_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({bus.req_data, bus.req_tweak, bus.req_tag}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // A launch is held off while an undrained result occupies the output register.
  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    capture    = 1'b0;
    core_rst_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && (!rsp_valid_q || bus.rsp_ready)) begin
          pop     = 1'b1;
          state_n = S_LOAD;
        end
      end
      S_LOAD: state_n = S_RUN;
      S_RUN: begin
        core_rst_n = 1'b1;
        if (core_ready || timeout_hit) begin
          capture = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      core_in    <= '0;
      core_tweak <= '0;
      core_key   <= '0;
      cur_tag    <= '0;
      run_cnt    <= '0;
    end else begin
      if (pop) begin
        {core_in, core_tweak, cur_tag} <= fifo_rdata;
        core_key <= key;
      end
      if (state == S_LOAD)     run_cnt <= '0;
      else if (state == S_RUN) run_cnt <= run_cnt + CW'(1);
    end
  end

  // Capture takes priority over a same-cycle drain so the new result is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else if (capture) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= core_ready ? core_out : '0;
      rsp_tag_q   <= cur_tag;
      rsp_err_q   <= ~core_ready;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_qarma64_req_ctrl.sv
// Self-checking bench for qarma64_req_ctrl with a fixed-latency behavioural core stub.
module tb_qarma64_req_ctrl;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [127:0]     key = '0;
  logic             busy, core_rst_n, core_ready;
  logic [63:0]      core_in, core_tweak, core_out;
  logic [127:0]     core_key;
  logic             hang = 1'b0;
  logic [4:0]       c = '0;
  int unsigned      cyc = 0;
  int unsigned      vectors = 0;
  int unsigned      miscompares = 0;

  typedef struct {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;
  exp_t sbq[$];

  qarma64_req_ctrl_if #(.TAG_W(TAG_W)) bus ();

  qarma64_req_ctrl #(.DEPTH(2), .TAG_W(TAG_W), .TIMEOUT(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .key        (key),
    .bus        (bus),
    .busy       (busy),
    .core_rst_n (core_rst_n),
    .core_in    (core_in),
    .core_tweak (core_tweak),
    .core_key   (core_key),
    .core_out   (core_out),
    .core_ready (core_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mix(input logic [63:0] p, input logic [63:0] t, input logic [127:0] k);
    logic [63:0] r;
    r = {p[50:0], p[63:51]} ^ t;
    r = r + k[63:0];
    r = r ^ {k[95:64], k[127:96]};
    return r;
  endfunction

  // Core stub: ready on the 17th cycle out of load, never when hung.
  always @(posedge clk) begin
    if (!core_rst_n)      c <= '0;
    else if (c != 5'd31)  c <= c + 5'd1;
  end
  assign core_ready = core_rst_n && !hang && (c == 5'd16);
  assign core_out   = core_ready ? mix(core_in, core_tweak, core_key) : 64'h0;

  task automatic push_req(input logic [63:0] p, input logic [63:0] t, input logic [TAG_W-1:0] tg,
                          input logic hung, output int unsigned at, output bit ok);
    exp_t e;
    bit got = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_data  = p;
    bus.req_tweak = t;
    bus.req_tag   = tg;
    for (int i = 0; i < 100 && !got; i++) begin
      if (bus.req_ready) got = 1'b1;
      else @(negedge clk);
    end
    at = 0;
    if (got) begin
      @(negedge clk);
      at = cyc;
      e.data = hung ? 64'h0 : mix(p, t, key);
      e.tag  = tg;
      e.err  = hung;
      sbq.push_back(e);
    end
    bus.req_valid = 1'b0;
    ok = got;
  endtask

  task automatic wait_valid(output int unsigned at, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    at = cyc;
  endtask

  task automatic test_reset;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (core_rst_n !== 1'b0) begin miscompares++; $display("FAIL reset_core_rst_n got=%b exp=0", core_rst_n); end
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    vectors++; if ({bus.rsp_data, bus.rsp_tag, bus.rsp_err} !== '0) begin miscompares++; $display("FAIL reset_rsp_regs got=%h/%h/%b exp=0", bus.rsp_data, bus.rsp_tag, bus.rsp_err); end
    vectors++; if ({core_in, core_tweak, core_key} !== '0) begin miscompares++; $display("FAIL reset_operands got=%h/%h/%h exp=0", core_in, core_tweak, core_key); end
    reset = 1'b0;
  endtask

  task automatic test_single;
    int unsigned p0, at;
    bit ok, seen;
    exp_t e;
    key = 128'h84be85ce9804e94b_ec2802d4e0a488e9;
    push_req(64'hfb623599da6e8127, 64'h477d469dec0b8762, 4'd5, 1'b0, p0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL single_push got=timeout exp=accepted"); end
    wait_valid(at, seen);
    vectors++;
    if (!seen || sbq.size() == 0) begin miscompares++; $display("FAIL single_rsp got=none exp=result"); end
    else begin
      e = sbq.pop_front();
      if ({bus.rsp_data, bus.rsp_tag, bus.rsp_err} !== {e.data, e.tag, e.err}) begin
        miscompares++; $display("FAIL single_rsp got=%h/%h/%b exp=%h/%h/%b", bus.rsp_data, bus.rsp_tag, bus.rsp_err, e.data, e.tag, e.err);
      end
      vectors++; if (at !== p0 + 19) begin miscompares++; $display("FAIL single_latency got=%0d exp=%0d", at - p0, 19); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int unsigned p[3], at, prev;
    bit ok[3], seen;
    exp_t e;
    key = 128'h0123456789abcdef_fedcba9876543210;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      push_req(64'h1111_2222_3333_4444 * (i + 3), 64'h5555_6666_7777_8888 ^ 64'(i), 4'(i + 8), 1'b0, p[i], ok[i]);
    vectors++; if (!(ok[0] && ok[1] && ok[2]) || p[2] !== p[0] + 2) begin miscompares++; $display("FAIL b2b_push_spacing got=%0d exp=2", p[2] - p[0]); end
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full got=%b exp=0", bus.req_ready); end
    prev = p[0];
    for (int i = 0; i < 3; i++) begin
      wait_valid(at, seen);
      vectors++;
      if (!seen || sbq.size() == 0) begin miscompares++; $display("FAIL b2b_rsp%0d got=none exp=result", i); end
      else begin
        e = sbq.pop_front();
        if ({bus.rsp_data, bus.rsp_tag, bus.rsp_err} !== {e.data, e.tag, e.err}) begin
          miscompares++; $display("FAIL b2b_rsp%0d got=%h/%h/%b exp=%h/%h/%b", i, bus.rsp_data, bus.rsp_tag, bus.rsp_err, e.data, e.tag, e.err);
        end
        vectors++; if (at !== prev + 19) begin miscompares++; $display("FAIL b2b_spacing%0d got=%0d exp=19", i, at - prev); end
      end
      prev = at;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    int unsigned px, py, at, r;
    bit okx, oky, seen, held;
    logic [63:0] hold_data;
    exp_t e;
    bus.rsp_ready = 1'b0;
    push_req(64'hdeadbeef00c0ffee, 64'h0f0f0f0f0f0f0f0f, 4'd3, 1'b0, px, okx);
    push_req(64'hcafebabe12345678, 64'hf0f0f0f0a5a5a5a5, 4'd12, 1'b0, py, oky);
    wait_valid(at, seen);
    vectors++;
    if (!seen || sbq.size() == 0) begin miscompares++; $display("FAIL bp_first got=none exp=result"); end
    else begin
      e = sbq.pop_front();
      if ({bus.rsp_data, bus.rsp_tag, bus.rsp_err} !== {e.data, e.tag, e.err}) begin
        miscompares++; $display("FAIL bp_first got=%h/%h/%b exp=%h/%h/%b", bus.rsp_data, bus.rsp_tag, bus.rsp_err, e.data, e.tag, e.err);
      end
    end
    hold_data = e.data;
    held = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!(bus.rsp_valid === 1'b1 && bus.rsp_data === hold_data && core_rst_n === 1'b0 && busy === 1'b1)) held = 1'b0;
    end
    vectors++; if (!held) begin miscompares++; $display("FAIL bp_hold got=valid%b/data%h/core_rst_n%b exp=1/%h/0", bus.rsp_valid, bus.rsp_data, core_rst_n, hold_data); end
    bus.rsp_ready = 1'b1;
    r = cyc;
    @(negedge clk);
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got=%b exp=0", bus.rsp_valid); end
    wait_valid(at, seen);
    vectors++;
    if (!seen || sbq.size() == 0) begin miscompares++; $display("FAIL bp_second got=none exp=result"); end
    else begin
      e = sbq.pop_front();
      if ({bus.rsp_data, bus.rsp_tag, bus.rsp_err} !== {e.data, e.tag, e.err}) begin
        miscompares++; $display("FAIL bp_second got=%h/%h/%b exp=%h/%h/%b", bus.rsp_data, bus.rsp_tag, bus.rsp_err, e.data, e.tag, e.err);
      end
      vectors++; if (at !== r + 19) begin miscompares++; $display("FAIL bp_latency got=%0d exp=19", at - r); end
    end
    @(negedge clk);
  endtask

  task automatic test_hung_core;
    int unsigned p0, at;
    bit ok, seen;
    exp_t e;
    bus.rsp_ready = 1'b1;
    hang = 1'b1;
    push_req(64'h0badf00d0badf00d, 64'h1234123412341234, 4'd9, 1'b1, p0, ok);
    wait_valid(at, seen);
    vectors++;
    if (!seen || sbq.size() == 0) begin miscompares++; $display("FAIL hung_rsp got=none exp=err result"); end
    else begin
      e = sbq.pop_front();
      if ({bus.rsp_data, bus.rsp_tag, bus.rsp_err} !== {e.data, e.tag, e.err}) begin
        miscompares++; $display("FAIL hung_rsp got=%h/%h/%b exp=%h/%h/%b", bus.rsp_data, bus.rsp_tag, bus.rsp_err, e.data, e.tag, e.err);
      end
      vectors++; if (at !== p0 + 26) begin miscompares++; $display("FAIL hung_latency got=%0d exp=26", at - p0); end
    end
    @(negedge clk);
    hang = 1'b0;
    push_req(64'h7777aaaa5555cccc, 64'h0000ffff0000ffff, 4'd1, 1'b0, p0, ok);
    wait_valid(at, seen);
    vectors++;
    if (!seen || sbq.size() == 0) begin miscompares++; $display("FAIL hung_next got=none exp=result"); end
    else begin
      e = sbq.pop_front();
      if ({bus.rsp_data, bus.rsp_tag, bus.rsp_err} !== {e.data, e.tag, e.err}) begin
        miscompares++; $display("FAIL hung_next got=%h/%h/%b exp=%h/%h/%b", bus.rsp_data, bus.rsp_tag, bus.rsp_err, e.data, e.tag, e.err);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_midrun_reset;
    int unsigned pz, pw, at;
    bit okz, okw, seen, quiet;
    exp_t e;
    bus.rsp_ready = 1'b1;
    push_req(64'h1357924680acebdf, 64'h2468ace013579bdf, 4'd6, 1'b0, pz, okz);
    push_req(64'h0f1e2d3c4b5a6978, 64'h8796a5b4c3d2e1f0, 4'd7, 1'b0, pw, okw);
    for (int i = 0; i < 50 && cyc < pz + 9; i++) @(negedge clk);
    vectors++; if (core_rst_n !== 1'b1 || cyc !== pz + 9) begin miscompares++; $display("FAIL mr_in_run got=core_rst_n%b/cyc%0d exp=1/%0d", core_rst_n, cyc - pz, 9); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    vectors++; if (busy !== 1'b0 || bus.req_ready !== 1'b1 || core_rst_n !== 1'b0) begin
      miscompares++; $display("FAIL mr_after_reset got=busy%b/req_ready%b/core_rst_n%b exp=0/1/0", busy, bus.req_ready, core_rst_n);
    end
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (bus.rsp_valid !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    vectors++; if (!quiet) begin miscompares++; $display("FAIL mr_no_result got=rsp_valid seen exp=none"); end
    push_req(64'h99887766554433aa, 64'h1020304050607080, 4'd14, 1'b0, pz, okz);
    wait_valid(at, seen);
    vectors++;
    if (!seen || sbq.size() == 0) begin miscompares++; $display("FAIL mr_next got=none exp=result"); end
    else begin
      e = sbq.pop_front();
      if ({bus.rsp_data, bus.rsp_tag, bus.rsp_err} !== {e.data, e.tag, e.err}) begin
        miscompares++; $display("FAIL mr_next got=%h/%h/%b exp=%h/%h/%b", bus.rsp_data, bus.rsp_tag, bus.rsp_err, e.data, e.tag, e.err);
      end
      vectors++; if (at !== pz + 19) begin miscompares++; $display("FAIL mr_latency got=%0d exp=19", at - pz); end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.req_tweak = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_hung_core();
    test_midrun_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit got=expired exp=finished");
    $fatal(1, "time limit reached");
  end
endmodule
